// File: rtl/data_mem_resp_pkg.sv
// Shared constants and helpers for the data-memory responder and its write buffer.
package data_mem_resp_pkg;

    localparam int WORD_W             = 32;
    localparam int ADDR_W_DEFAULT     = 8;
    localparam int WBUF_DEPTH_DEFAULT = 4;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_resp_wbuf_fifo.sv
// Circular write buffer holding {word index, data} pairs, with a youngest-match
// lookup so reads can see writes that have not yet drained into the array.
module wbuf_fifo
    import data_mem_resp_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [IDX_W-1:0]  push_idx,
    input  logic [WORD_W-1:0] push_data,
    input  logic [IDX_W-1:0]  lookup_idx,
    output logic [IDX_W-1:0]  head_idx,
    output logic [WORD_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              hit,
    output logic [WORD_W-1:0] hit_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0]  idx_q  [DEPTH];
    logic [WORD_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  pos;

    // Control state: pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful for slots covered by count.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[tail]  <= push_idx;
            data_q[tail] <= push_data;
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_idx  = idx_q[head];
    assign head_data = data_q[head];

    // Walk oldest to youngest so the last match found is the newest write.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        pos      = head;
        for (int i = 0; i < DEPTH; i++) begin
            pos = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (idx_q[pos] == lookup_idx)) begin
                hit      = 1'b1;
                hit_data = data_q[pos];
            end
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: same-cycle reads with write-buffer bypass, posted
// writes that drain into the word array whenever the core port is free.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEFAULT,
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_ren,
    input  logic                 mem_wen,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_dout,
    output logic [31:0]          mem_din,
    output logic                 mem_stall,
    output logic [CNT_WIDTH-1:0] wbuf_count,
    output logic                 align_err
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0]     mem_array [WORDS];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0] head_idx;
    logic [WORD_W-1:0]     head_data;
    logic [WORD_W-1:0]     hit_data;
    logic                  hit;
    logic                  full;
    logic                  empty;
    logic                  access;
    logic                  push;
    logic                  drain;
    logic                  unused_addr_bits;

    // Upper address bits are ignored so the array aliases modulo its size.
    assign word_idx         = mem_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

    // A write to a full buffer is stalled; that cycle counts as a free port,
    // so the head drains and the retried write finds room next cycle.
    assign access    = mem_ren | mem_wen;
    assign mem_stall = mem_wen & full;
    assign push      = mem_wen & ~full;
    assign drain     = (~access | mem_stall) & ~empty;

    wbuf_fifo #(
        .IDX_W (ADDR_WIDTH),
        .DEPTH (WBUF_DEPTH),
        .CNT_W (CNT_WIDTH)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (drain),
        .push_idx   (word_idx),
        .push_data  (mem_dout),
        .lookup_idx (word_idx),
        .head_idx   (head_idx),
        .head_data  (head_data),
        .count      (wbuf_count),
        .full       (full),
        .empty      (empty),
        .hit        (hit),
        .hit_data   (hit_data)
    );

    // Array update: reset clears every word; otherwise retire the buffer head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem_array[i] <= '0;
        end else if (drain) begin
            mem_array[head_idx] <= head_data;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            align_err <= 1'b0;
        else if (access && is_misaligned(mem_addr[1:0]))
            align_err <= 1'b1;
    end

    // Read data: newest buffered write wins over the array; zero when idle.
    always_comb begin
        mem_din = '0;
        if (mem_ren) mem_din = hit ? hit_data : mem_array[word_idx];
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed scoreboard bench for data_mem_resp: stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic [2:0]  wbuf_count;
    logic        align_err;

    typedef struct {
        logic [31:0] din;
        logic        stall;
        logic [2:0]  cnt;
        logic        err;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;
    logic end_checked = 1'b0;

    always #5 clk = ~clk;

    data_mem_resp dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_stall  (mem_stall),
        .wbuf_count (wbuf_count),
        .align_err  (align_err)
    );

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            checks++;
            if (mem_din !== e_mon.din) begin
                errors++;
                $display("FAIL %s mem_din: got %h expected %h", e_mon.name, mem_din, e_mon.din);
            end
            checks++;
            if (mem_stall !== e_mon.stall) begin
                errors++;
                $display("FAIL %s mem_stall: got %b expected %b", e_mon.name, mem_stall, e_mon.stall);
            end
            checks++;
            if (wbuf_count !== e_mon.cnt) begin
                errors++;
                $display("FAIL %s wbuf_count: got %0d expected %0d", e_mon.name, wbuf_count, e_mon.cnt);
            end
            checks++;
            if (align_err !== e_mon.err) begin
                errors++;
                $display("FAIL %s align_err: got %b expected %b", e_mon.name, align_err, e_mon.err);
            end
        end else if (done && !end_checked) begin
            end_checked = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
            end
        end
    end

    task automatic step(input logic r, input logic rn, input logic wn,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chk, input logic [31:0] e_din,
                        input logic e_stall, input logic [2:0] e_cnt,
                        input logic e_err, input string nm);
        exp_t item;
        @(posedge clk);
        #1;
        rst      = r;
        mem_ren  = rn;
        mem_wen  = wn;
        mem_addr = a;
        mem_dout = d;
        if (chk) begin
            item.din   = e_din;
            item.stall = e_stall;
            item.cnt   = e_cnt;
            item.err   = e_err;
            item.name  = nm;
            exp_q.push_back(item);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e_din,
                      input logic [2:0] e_cnt, input logic e_err, input string nm);
        step(1'b0, 1'b1, 1'b0, a, 32'h0, 1'b1, e_din, 1'b0, e_cnt, e_err, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic e_stall,
                      input logic [2:0] e_cnt, input logic e_err, input string nm);
        step(1'b0, 1'b0, 1'b1, a, d, 1'b1, 32'h0, e_stall, e_cnt, e_err, nm);
    endtask

    task automatic idle(input logic [2:0] e_cnt, input logic e_err, input string nm);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, e_cnt, e_err, nm);
    endtask

    initial begin
        rst      = 1'b1;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_dout = '0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, "rst");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, "rst");

        // Reset state
        rd(32'h10, 32'h0, 3'd0, 1'b0, "reset_read");

        // Single write, bypass then array read after one idle cycle
        wr(32'h20, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, "wr_deadbeef");
        rd(32'h20, 32'hDEADBEEF, 3'd1, 1'b0, "bypass_deadbeef");
        idle(3'd1, 1'b0, "drain1");
        rd(32'h20, 32'hDEADBEEF, 3'd0, 1'b0, "array_deadbeef");

        // Same-index ordering
        wr(32'h20, 32'h1, 1'b0, 3'd0, 1'b0, "wr_20_1");
        wr(32'h20, 32'h2, 1'b0, 3'd1, 1'b0, "wr_20_2");
        rd(32'h20, 32'h2, 3'd2, 1'b0, "bypass_youngest");
        idle(3'd2, 1'b0, "drain_a");
        idle(3'd1, 1'b0, "drain_b");
        rd(32'h20, 32'h2, 3'd0, 1'b0, "array_order");

        // Fill, stall with drain, retry
        wr(32'h00, 32'h1, 1'b0, 3'd0, 1'b0, "fill0");
        wr(32'h04, 32'h2, 1'b0, 3'd1, 1'b0, "fill1");
        wr(32'h08, 32'h3, 1'b0, 3'd2, 1'b0, "fill2");
        wr(32'h0C, 32'h4, 1'b0, 3'd3, 1'b0, "fill3");
        wr(32'h10, 32'h5, 1'b1, 3'd4, 1'b0, "full_stall");
        wr(32'h10, 32'h5, 1'b0, 3'd3, 1'b0, "retry");
        rd(32'h10, 32'h5, 3'd4, 1'b0, "bypass_retry");
        idle(3'd4, 1'b0, "drain4");
        idle(3'd3, 1'b0, "drain3");
        idle(3'd2, 1'b0, "drain2");
        idle(3'd1, 1'b0, "drain1b");
        rd(32'h00, 32'h1, 3'd0, 1'b0, "rb0");
        rd(32'h04, 32'h2, 3'd0, 1'b0, "rb1");
        rd(32'h08, 32'h3, 3'd0, 1'b0, "rb2");
        rd(32'h0C, 32'h4, 3'd0, 1'b0, "rb3");
        rd(32'h10, 32'h5, 3'd0, 1'b0, "rb4");

        // Read and write together: write wins, read shows pre-write value
        step(1'b0, 1'b1, 1'b1, 32'h20, 32'h33, 1'b1, 32'h2, 1'b0, 3'd0, 1'b0, "rw_both");
        rd(32'h20, 32'h33, 3'd1, 1'b0, "rw_after");
        idle(3'd1, 1'b0, "drain_rw");

        // Address wrap modulo array size
        wr(32'h3FC, 32'hCAFE0001, 1'b0, 3'd0, 1'b0, "wr_wrap");
        rd(32'h7FC, 32'hCAFE0001, 3'd1, 1'b0, "wrap_bypass");
        idle(3'd1, 1'b0, "drain_wrap");
        rd(32'h7FC, 32'hCAFE0001, 3'd0, 1'b0, "wrap_array");

        // Misalignment is sticky
        rd(32'h22, 32'h33, 3'd0, 1'b0, "misalign_access");
        rd(32'h20, 32'h33, 3'd0, 1'b1, "align_err_set");
        idle(3'd0, 1'b1, "align_err_hold");

        // Reset with buffered writes discards them and clears the array
        wr(32'h40, 32'h7, 1'b0, 3'd0, 1'b1, "pre_rst0");
        wr(32'h44, 32'h8, 1'b0, 3'd1, 1'b1, "pre_rst1");
        wr(32'h48, 32'h9, 1'b0, 3'd2, 1'b1, "pre_rst2");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 3'd3, 1'b1, "rst_cycle");
        rd(32'h40, 32'h0, 3'd0, 1'b0, "post_rst_40");
        rd(32'h44, 32'h0, 3'd0, 1'b0, "post_rst_44");
        rd(32'h48, 32'h0, 3'd0, 1'b0, "post_rst_48");
        rd(32'h20, 32'h0, 3'd0, 1'b0, "post_rst_20");
        rd(32'h7FC, 32'h0, 3'd0, 1'b0, "post_rst_7fc");
        idle(3'd0, 1'b0, "post_rst_idle");

        repeat (3) @(posedge clk);
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
